controller: RTL and testbench

- Multicycle control FSM for the 8-bit MIPS datapath.
- Consumes the opcode (instr[31:26]), funct (instr[5:0]) and the ALU zero flag from the datapath.
- Produces every datapath control strobe: mux selects, register/IR/PC enables, memory read/write and ALU operation.
- Moore outputs decoded from the state register, plus one Mealy term (pcen, which depends on zero).

---
 rtl/controller_pkg.sv | 46 ++++
 rtl/controller_aludec.sv | 22 ++
 rtl/controller.sv | 110 +++++++++++
 tb/tb_controller.sv | 137 +++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// controller_pkg: state encodings, opcode/funct constants and control-field encodings for the multicycle MIPS controller
package controller_pkg;
  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_X4  = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/controller_aludec.sv
// aludec: maps aluop (+ funct for R-type) to alucontrol; ports aluop[1:0], funct[5:0] in, alucontrol[2:0] out
module aludec
  import controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = ALU_ADD;
    if (aluop == ALUOP_SUB)
      alucontrol = ALU_SUB;
    else if (aluop == ALUOP_FUNCT)
      case (funct)
        F_SUB:   alucontrol = ALU_SUB;
        F_AND:   alucontrol = ALU_AND;
        F_OR:    alucontrol = ALU_OR;
        F_SLT:   alucontrol = ALU_SLT;
        default: alucontrol = ALU_ADD;
      endcase
  end
endmodule

// File: rtl/controller.sv
// controller: multicycle MIPS control FSM; in clk/reset/op/funct/zero, out all datapath strobes, alucontrol and pcen
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [1:0] pcsource,
  output logic       pcen
);
  state_t state, next_state;
  logic [1:0] aluop;
  logic pcwrite, pcwritecond;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH1;
    else state <= next_state;
  always_comb begin
    next_state = FETCH1;
    case (state)
      FETCH1:  next_state = FETCH2;
      FETCH2:  next_state = FETCH3;
      FETCH3:  next_state = FETCH4;
      FETCH4:  next_state = DECODE;
      DECODE:
        case (op)
          OP_LB, OP_SB: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
          OP_J:         next_state = JEX;
          OP_ADDI:      next_state = ADDIEX;
          default:      next_state = FETCH1;
        endcase
      MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    next_state = LBWR;
      RTYPEEX: next_state = RTYPEWR;
      ADDIEX:  next_state = ADDIWR;
      default: next_state = FETCH1;
    endcase
  end
  always_comb begin
    memread = 1'b0;
    memwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_B;
    aluop = ALUOP_ADD;
    iord = 1'b0;
    irwrite = 4'b0000;
    memtoreg = 1'b0;
    regdst = 1'b0;
    regwrite = 1'b0;
    pcsource = PC_ALU;
    pcwrite = 1'b0;
    pcwritecond = 1'b0;
    case (state)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread = 1'b1;
        iord = 1'b1;
        alusrca = 1'b1;
        alusrcb = SRCB_ONE;
        pcwrite = 1'b1;
        irwrite = 4'b0001 << state[1:0];
      end
      DECODE: begin
        alusrca = 1'b1;
        alusrcb = SRCB_X4;
      end
      MEMADR, ADDIEX: alusrcb = SRCB_IMM;
      LBRD: memread = 1'b1;
      LBWR: begin
        regwrite = 1'b1;
        regdst = 1'b1;
      end
      SBWR: memwrite = 1'b1;
      RTYPEEX: aluop = ALUOP_FUNCT;
      RTYPEWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      BEQEX: begin
        aluop = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource = PC_ALUOUT;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsource = PC_JUMP;
      end
      ADDIWR: begin
        regwrite = 1'b1;
        regdst = 1'b1;
        memtoreg = 1'b1;
      end
      default: ;
    endcase
  end
  assign pcen = pcwrite | (pcwritecond & zero);
  aludec u_aludec (.aluop(aluop), .funct(funct), .alucontrol(alucontrol));
endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized check of controller against a per-instruction step model
module tb_controller;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       iord;
    logic [3:0] irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcen;
  } outs_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;
  logic memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucontrol;
  logic [3:0] irwrite;
  outs_t got;
  int total = 0;
  int bad = 0;
  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .pcsource(pcsource), .pcen(pcen)
  );
  assign got = {memread, memwrite, alusrca, alusrcb, alucontrol, iord, irwrite,
                memtoreg, regdst, regwrite, pcsource, pcen};
  always #5 clk = ~clk;
  function automatic int lat(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010: return 6;
      default: return 5;
    endcase
  endfunction
  function automatic logic [2:0] fdec(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int step);
    outs_t e = '0;
    int k = step - 5;
    e.alucontrol = 3'b010;
    if (step < 4) begin
      e.memread = 1; e.iord = 1; e.alusrca = 1; e.alusrcb = 2'b01; e.pcen = 1;
      e.irwrite = 4'(1 << step);
    end else if (step == 4) begin
      e.alusrca = 1; e.alusrcb = 2'b11;
    end else
      case (o)
        6'b100000: if (k == 0) e.alusrcb = 2'b10;
                   else if (k == 1) e.memread = 1;
                   else begin e.regwrite = 1; e.regdst = 1; end
        6'b101000: if (k == 0) e.alusrcb = 2'b10; else e.memwrite = 1;
        6'b000000: if (k == 0) e.alucontrol = fdec(f);
                   else begin e.regwrite = 1; e.memtoreg = 1; end
        6'b000100: begin e.alucontrol = 3'b110; e.pcsource = 2'b01; e.pcen = z; end
        6'b000010: begin e.pcen = 1; e.pcsource = 2'b10; end
        6'b001000: if (k == 0) e.alusrcb = 2'b10;
                   else begin e.regwrite = 1; e.regdst = 1; e.memtoreg = 1; end
        default: ;
      endcase
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    for (int s = 0; s < lat(o); s++) begin
      zero = 1'($urandom);
      #1 chk($sformatf("op%b f%b step%0d", o, f, s), 32'(got), 32'(model(o, f, zero, s)));
      zero = ~zero;
      #1 chk($sformatf("op%b f%b step%0d zt", o, f, s), 32'(got), 32'(model(o, f, zero, s)));
      if (s == 0) chk("fetch1_irwrite", 32'(irwrite), 32'h1);
      @(negedge clk);
    end
  endtask
  logic [5:0] ops [7] = '{6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
  logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irwrite", 32'(irwrite), 32'h1);
    chk("rst_memread", 32'(memread), 32'h1);
    chk("rst_iord", 32'(iord), 32'h1);
    chk("rst_pcen", 32'(pcen), 32'h1);
    chk("rst_alusrcb", 32'(alusrcb), 32'h1);
    reset = 1'b0;
    op = 6'b100000;
    repeat (5) @(negedge clk);
    chk("memadr_alusrcb", 32'(alusrcb), 32'h2);
    chk("memadr_irwrite", 32'(irwrite), 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("async_irwrite", 32'(irwrite), 32'h1);
    chk("async_memread", 32'(memread), 32'h1);
    chk("async_iord", 32'(iord), 32'h1);
    chk("async_regwrite", 32'(regwrite), 32'h0);
    chk("async_memwrite", 32'(memwrite), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'b000000, 6'b100000);
    run_instr(6'b100000, 6'd0);
    run_instr(6'b101000, 6'd0);
    run_instr(6'b000100, 6'd0);
    run_instr(6'b000010, 6'd0);
    run_instr(6'b111111, 6'd0);
    run_instr(6'b001000, 6'd0);
    for (int i = 0; i < 6; i++) run_instr(6'b000000, fns[i]);
    for (int i = 0; i < 300; i++)
      run_instr(($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)],
                ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
